sha3_burst_feeder: RTL and testbench

Upstream stage of sha3_iterating_pipe6. Collects 1600-bit states one at a time from a producer and holds them as a burst of BURST matrices. When the pipe's gimme is high, it delivers that burst on exactly BURST consecutive clocks, which is what the pipe requires once it starts sampling. Partial bursts are completed with all-zero dummy states on flush or timeout, and the number of dummies is reported for downstream discard.

---
 rtl/sha3_burst_feeder_if.sv | 9 +
 rtl/sha3_burst_feeder.sv | 160 ++++++++++++++++
 tb/tb_sha3_burst_feeder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sha3_burst_feeder_if.sv
// 1600-bit Keccak state bus: one 5x5 matrix of 64-bit lanes per sample beat.
// rows[x][y] is lane (x,y); lane [0][0] occupies the lowest 64 bits.
interface i_sha3_1600_row_bus;
    logic                     sample;
    logic [4:0][4:0][63:0]    rows;

    modport controller (output sample, output rows);
    modport periph     (input  sample, input  rows);
endinterface

// File: rtl/sha3_burst_feeder.sv
// Gathers single 1600-bit states into a burst of BURST matrices and replays the
// burst on BURST back-to-back clocks once the downstream pipe raises gimme.
module sha3_burst_feeder #(
    parameter int BURST   = 14,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    i_sha3_1600_row_bus.periph       busin,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     gimme,
    i_sha3_1600_row_bus.controller   busout,
    output logic [3:0]               pad_count,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        FILL,
        ARMED,
        EMIT
    } state_e;

    localparam int                IDLE_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]        BURST_N    = 4'(BURST);
    localparam logic [3:0]        LAST_IDX   = 4'(BURST - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic              TIMEOUT_EN = (TIMEOUT != 0);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic [3:0]              pad_q, pad_d;
    logic                    ovf_q, ovf_d;
    logic                    osample_q, osample_d;
    logic [4:0][4:0][63:0]   orows_q, orows_d;

    logic [4:0][4:0][63:0]   mem_q [BURST];

    logic                    accept;
    logic                    pad_req;
    logic [3:0]              cnt_after;
    logic [3:0]              idx_nxt;
    logic [3:0]              real_n;

    assign in_ready  = (state_q == FILL) && (cnt_q < BURST_N);
    assign accept    = busin.sample && in_ready;
    assign cnt_after = cnt_q + {3'b000, accept};
    assign pad_req   = flush || (TIMEOUT_EN && (idle_q == IDLE_LAST));
    assign idx_nxt   = idx_q + 4'd1;
    assign real_n    = BURST_N - pad_q;

    assign busout.sample = osample_q;
    assign busout.rows   = orows_q;
    assign pad_count     = pad_q;
    assign overflow      = ovf_q;

    // State register and all control/output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            idx_q     <= '0;
            idle_q    <= '0;
            pad_q     <= '0;
            ovf_q     <= 1'b0;
            osample_q <= 1'b0;
            orows_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            idle_q    <= idle_d;
            pad_q     <= pad_d;
            ovf_q     <= ovf_d;
            osample_q <= osample_d;
            orows_q   <= orows_d;
        end
    end

    // Burst storage is deliberately not reset; only cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem_q[cnt_q] <= busin.rows;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                // The accept of this clock counts before the pad decision.
                if ((cnt_after == BURST_N) || (pad_req && (cnt_after != 4'd0))) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (gimme) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        idle_d    = idle_q;
        pad_d     = pad_q;
        osample_d = osample_q;
        orows_d   = orows_q;
        ovf_d     = ovf_q | (busin.sample & ~in_ready);

        unique case (state_q)
            FILL: begin
                cnt_d = cnt_after;
                if (accept) begin
                    idle_d = '0;
                end else if (cnt_q != 4'd0) begin
                    idle_d = idle_q + 1'b1;
                end
                if (state_d == ARMED) begin
                    pad_d  = BURST_N - cnt_after;
                    idle_d = '0;
                end
            end
            ARMED: begin
                if (gimme) begin
                    idx_d     = '0;
                    osample_d = 1'b1;
                    orows_d   = mem_q[0];
                end
            end
            EMIT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d     = '0;
                    cnt_d     = '0;
                    idle_d    = '0;
                    osample_d = 1'b0;
                end else begin
                    // Registered output leads idx by one beat: load the next entry now.
                    idx_d     = idx_nxt;
                    osample_d = 1'b1;
                    orows_d   = (idx_nxt < real_n) ? mem_q[idx_nxt] : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha3_burst_feeder.sv
// Directed, table-driven bench for sha3_burst_feeder (BURST=14, TIMEOUT=8).
module tb_sha3_burst_feeder;

    localparam int BURST = 14;

    localparam int M_NONE  = 0;
    localparam int M_AFTER = 1;
    localparam int M_WITH  = 2;

    typedef struct {
        int           n;
        logic [63:0]  base;
        int           mode;
        int           pad;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       gimme = 1'b0;
    logic       in_ready;
    logic [3:0] pad_count;
    logic       overflow;

    int n_vec  = 0;
    int n_miss = 0;

    i_sha3_1600_row_bus bus_in ();
    i_sha3_1600_row_bus bus_out ();

    sha3_burst_feeder #(.BURST(14), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .busin     (bus_in),
        .in_ready  (in_ready),
        .flush     (flush),
        .gimme     (gimme),
        .busout    (bus_out),
        .pad_count (pad_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0][4:0][63:0] make_state(input logic [63:0] v);
        logic [4:0][4:0][63:0] r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = v ^ {32'(x * 5 + y), 32'h0};
        return r;
    endfunction

    function automatic logic [63:0] fold(input logic [4:0][4:0][63:0] r);
        logic [63:0] s = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s = s + r[x][y] * 64'(x * 5 + y + 1);
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pushes n states; returns at the negedge after the last driven edge.
    task automatic push_n(input logic [63:0] base, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            check("in_ready_before_push", 64'(in_ready), 64'd1);
            bus_in.sample = 1'b1;
            bus_in.rows   = make_state(base + 64'(i));
            flush         = (mode == M_WITH) && (i == n - 1);
            step();
        end
        bus_in.sample = 1'b0;
        bus_in.rows   = '0;
        flush         = 1'b0;
        if (mode == M_AFTER) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
    endtask

    // Called at a negedge in ARMED; gimme must already be high.
    task automatic collect_burst(input logic [63:0] base, input int exp_pad, input bit drop_gimme);
        logic [4:0][4:0][63:0] exp_r;
        step();
        for (int k = 0; k < BURST; k++) begin
            exp_r = (k < BURST - exp_pad) ? make_state(base + 64'(k)) : '0;
            check("burst_sample", 64'(bus_out.sample), 64'd1);
            check("burst_lane00", bus_out.rows[0][0], exp_r[0][0]);
            check("burst_fold", fold(bus_out.rows), fold(exp_r));
            check("burst_pad_count", 64'(pad_count), 64'(exp_pad));
            check("burst_in_ready", 64'(in_ready), 64'd0);
            if (drop_gimme && k == 1) gimme = 1'b0;
            step();
        end
        check("after_burst_sample", 64'(bus_out.sample), 64'd0);
        check("after_burst_in_ready", 64'(in_ready), 64'd1);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{n: 14, base: 64'd1,     mode: M_NONE,  pad: 0};
        tbl[1] = '{n: 5,  base: 64'hA0,    mode: M_AFTER, pad: 9};
        tbl[2] = '{n: 5,  base: 64'hB0,    mode: M_WITH,  pad: 9};
        tbl[3] = '{n: 14, base: 64'hC0,    mode: M_WITH,  pad: 0};
        tbl[4] = '{n: 1,  base: 64'hD0,    mode: M_AFTER, pad: 13};
        tbl[5] = '{n: 13, base: 64'hE0,    mode: M_AFTER, pad: 1};

        bus_in.sample = 1'b0;
        bus_in.rows   = '0;
        repeat (3) step();
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_sample", 64'(bus_out.sample), 64'd0);
        check("reset_lane00", bus_out.rows[0][0], 64'd0);
        check("reset_pad_count", 64'(pad_count), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        // flush and long idle with an empty buffer must never arm
        flush = 1'b1;
        repeat (3) begin
            step();
            check("empty_flush_in_ready", 64'(in_ready), 64'd1);
        end
        flush = 1'b0;
        repeat (20) step();
        check("empty_idle_in_ready", 64'(in_ready), 64'd1);

        // table-driven bursts with gimme held high
        gimme = 1'b1;
        for (int v = 0; v < 6; v++) begin
            push_n(tbl[v].base, tbl[v].n, tbl[v].mode);
            check("armed_in_ready", 64'(in_ready), 64'd0);
            check("armed_sample", 64'(bus_out.sample), 64'd0);
            check("armed_pad_count", 64'(pad_count), 64'(tbl[v].pad));
            collect_burst(tbl[v].base, tbl[v].pad, 1'b0);
        end

        // timeout: arms exactly 8 clocks after the last accept
        gimme = 1'b0;
        push_n(64'h30, 3, M_NONE);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("timeout_in_ready", 64'(in_ready), (k < 8) ? 64'd1 : 64'd0);
        end
        check("timeout_pad_count", 64'(pad_count), 64'd11);
        gimme = 1'b1;
        collect_burst(64'h30, 11, 1'b0);

        // gimme gating, then gimme dropped early in the burst
        gimme = 1'b0;
        push_n(64'h100, 14, M_NONE);
        for (int k = 0; k < 50; k++) begin
            check("gated_sample", 64'(bus_out.sample), 64'd0);
            check("gated_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        gimme = 1'b1;
        collect_burst(64'h100, 0, 1'b1);

        // overflow while ARMED: dropped states must not disturb the buffer
        gimme = 1'b0;
        check("pre_overflow", 64'(overflow), 64'd0);
        push_n(64'h200, 14, M_NONE);
        bus_in.sample = 1'b1;
        bus_in.rows   = make_state(64'hDEAD);
        repeat (3) step();
        bus_in.sample = 1'b0;
        bus_in.rows   = '0;
        check("overflow_set", 64'(overflow), 64'd1);
        gimme = 1'b1;
        collect_burst(64'h200, 0, 1'b0);
        check("overflow_sticky", 64'(overflow), 64'd1);

        // reset in the middle of a burst
        push_n(64'h300, 14, M_NONE);
        step();
        for (int k = 0; k < 6; k++) begin
            check("pre_reset_sample", 64'(bus_out.sample), 64'd1);
            step();
        end
        rst = 1'b1;
        step();
        check("midrst_sample", 64'(bus_out.sample), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_lane00", bus_out.rows[0][0], 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_pad_count", 64'(pad_count), 64'd0);
        rst = 1'b0;
        push_n(64'h400, 14, M_NONE);
        check("fresh_armed_in_ready", 64'(in_ready), 64'd0);
        collect_burst(64'h400, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
